// File: rtl/crc16_pkg.sv
// Shared CRC-16-CCITT definitions for the transmit framer: polynomial, seed,
// framer state type and the byte-parallel CRC update.
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CRC_HI,
        CRC_LO
    } t_Frame_State;

    // One byte of CRC-16-CCITT, MSB first, non-reflected. The loop unrolls
    // into the usual byte-wide XOR network.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc;
        for (int k = 7; k >= 0; k--) begin
            if (c[15] ^ data[k]) begin
                c = {c[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_ccitt_frame_tx.sv
// Transmit framer: passes payload bytes through a one-deep output register
// and appends CRC-16-CCITT (MSB first) after the last byte of each frame.
// Frames reaching MAX_BYTES without a last marker are closed early and o_Err
// pulses. Optional build macro CRC_FRAME_TX_STATS_EN adds frame/truncation
// counters as extra outputs.
//
// state   | meaning
// IDLE    | between frames, CRC seeded, waiting for the first byte
// PAYLOAD | mid-frame, CRC accumulating over accepted bytes
// CRC_HI  | waiting for a free output slot to emit CRC[15:8]
// CRC_LO  | waiting for a free output slot to emit CRC[7:0] with o_Last
module crc16_ccitt_frame_tx
    import crc16_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 256,
    parameter logic [15:0] CRC_INIT  = CRC16_INIT
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_DV,
    input  logic [7:0]  i_Data,
    input  logic        i_Last,
    output logic        o_Ready,
    output logic        o_DV,
    output logic [7:0]  o_Data,
    output logic        o_Last,
    input  logic        i_Ready,
`ifdef CRC_FRAME_TX_STATS_EN
    output logic [15:0] o_Frame_Count,
    output logic [15:0] o_Trunc_Count,
`endif
    output logic        o_Err
);

    localparam logic [15:0] MAX_CNT = MAX_BYTES[15:0];

    t_Frame_State state_q, state_d;
    logic [15:0]  crc_q, crc_d;
    logic [15:0]  count_q, count_d;
    logic         dv_d, last_d, err_d;
    logic [7:0]   data_d;
    logic         frame_done;

    logic         free;
    logic         xfer;
    logic [15:0]  crc_base;
    logic [15:0]  count_next;
    logic         hit_max;

    // Output slot availability, input handshake and per-byte bookkeeping.
    always_comb begin
        free       = !o_DV || i_Ready;
        o_Ready    = ((state_q == IDLE) || (state_q == PAYLOAD)) && free;
        xfer       = i_DV && o_Ready;
        crc_base   = (state_q == IDLE) ? CRC_INIT : crc_q;
        count_next = ((state_q == IDLE) ? 16'd0 : count_q) + 16'd1;
        hit_max    = (count_next == MAX_CNT);
    end

    // Next-state and output-register loading.
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        count_d    = count_q;
        dv_d       = o_DV && !i_Ready;
        data_d     = o_Data;
        last_d     = o_Last;
        err_d      = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            IDLE, PAYLOAD: begin
                if (state_q == IDLE) begin
                    crc_d   = CRC_INIT;
                    count_d = 16'd0;
                end
                if (xfer) begin
                    crc_d   = crc16_step(crc_base, i_Data);
                    count_d = count_next;
                    dv_d    = 1'b1;
                    data_d  = i_Data;
                    last_d  = 1'b0;
                    if (i_Last || hit_max) begin
                        state_d = CRC_HI;
                        err_d   = !i_Last;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            CRC_HI: begin
                if (free) begin
                    dv_d    = 1'b1;
                    data_d  = crc_q[15:8];
                    last_d  = 1'b0;
                    state_d = CRC_LO;
                end
            end
            CRC_LO: begin
                if (free) begin
                    dv_d       = 1'b1;
                    data_d     = crc_q[7:0];
                    last_d     = 1'b1;
                    state_d    = IDLE;
                    crc_d      = CRC_INIT;
                    count_d    = 16'd0;
                    frame_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                crc_d   = CRC_INIT;
                count_d = 16'd0;
            end
        endcase
    end

    // State, CRC, byte count and registered output byte.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            count_q <= 16'd0;
            o_DV    <= 1'b0;
            o_Data  <= 8'd0;
            o_Last  <= 1'b0;
            o_Err   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            count_q <= count_d;
            o_DV    <= dv_d;
            o_Data  <= data_d;
            o_Last  <= last_d;
            o_Err   <= err_d;
        end
    end

`ifdef CRC_FRAME_TX_STATS_EN
    // Frame counter wraps; truncation counter sticks at full scale.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Frame_Count <= 16'd0;
            o_Trunc_Count <= 16'd0;
        end else begin
            if (frame_done) begin
                o_Frame_Count <= o_Frame_Count + 16'd1;
            end
            if (o_Err && (o_Trunc_Count != 16'hFFFF)) begin
                o_Trunc_Count <= o_Trunc_Count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_crc16_ccitt_frame_tx.sv
// Bench for crc16_ccitt_frame_tx: one instance at the default frame limit and
// one limited to 4 bytes. Directed table vectors, multi-cycle corner cases and
// randomized frames checked against a table-driven CRC reference.
module tb_crc16_ccitt_frame_tx;

    localparam int MAXB0 = 256;
    localparam int MAXB1 = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] in_dv;
    logic [1:0] in_last;
    logic [1:0] ds_ready;
    logic [7:0] in_data [2];
    logic       rand_ready;

    wire  [1:0] o_ready;
    wire  [1:0] o_dv;
    wire  [1:0] o_last;
    wire  [1:0] o_err;
    wire  [7:0] o_data [2];
`ifdef CRC_FRAME_TX_STATS_EN
    wire  [15:0] frame_cnt [2];
    wire  [15:0] trunc_cnt [2];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        crc16_ccitt_frame_tx #(
            .MAX_BYTES((g == 0) ? MAXB0 : MAXB1),
            .CRC_INIT (16'hFFFF)
        ) u_dut (
            .i_Clk        (clk),
            .i_Rst_n      (rst_n),
            .i_DV         (in_dv[g]),
            .i_Data       (in_data[g]),
            .i_Last       (in_last[g]),
            .o_Ready      (o_ready[g]),
            .o_DV         (o_dv[g]),
            .o_Data       (o_data[g]),
            .o_Last       (o_last[g]),
            .i_Ready      (ds_ready[g]),
`ifdef CRC_FRAME_TX_STATS_EN
            .o_Frame_Count(frame_cnt[g]),
            .o_Trunc_Count(trunc_cnt[g]),
`endif
            .o_Err        (o_err[g])
        );
    end

    // ---------------- reference model ----------------
    logic [15:0] crc_tab [256];

    function automatic logic [15:0] model_crc(input logic [7:0] b[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[i]) c = {c[7:0], 8'h00} ^ crc_tab[c[15:8] ^ b[i]];
        return c;
    endfunction

    // Expected output stream: payload chunks of at most maxb bytes, each
    // closed by CRC hi/lo; chunks closed without a last marker count as errors.
    task automatic build_exp(input int maxb, input logic [7:0] b[$], input bit term,
                             inout logic [8:0] exp[$], inout int errs);
        logic [7:0]  chunk[$];
        logic [15:0] c;
        for (int i = 0; i < b.size(); i++) begin
            chunk.push_back(b[i]);
            exp.push_back({1'b0, b[i]});
            if ((term && i == b.size() - 1) || chunk.size() == maxb) begin
                if (!(term && i == b.size() - 1)) errs++;
                c = model_crc(chunk);
                exp.push_back({1'b0, c[15:8]});
                exp.push_back({1'b1, c[7:0]});
                chunk.delete();
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic [8:0] got_q [2][$];
    logic [7:0] err_data [2][$];
    int         err_seen   [2];
    int         stab_bad   [2];
    int         ready_viol [2];
    logic [1:0] hold_v;
    logic [7:0] hold_d [2];
    logic [1:0] pend;
    int         cnt_m [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            err_seen[i] = 0; stab_bad[i] = 0; ready_viol[i] = 0; cnt_m[i] = 0;
        end
        hold_v = '0;
        pend   = '0;
    end

    // Record accepted output bytes, hold stability, o_Ready during CRC emission.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                hold_v[i] <= 1'b0;
                pend[i]   <= 1'b0;
                cnt_m[i]  <= 0;
            end else begin
                if (o_dv[i] && ds_ready[i]) got_q[i].push_back({o_last[i], o_data[i]});
                if (o_err[i]) begin
                    err_seen[i] <= err_seen[i] + 1;
                    err_data[i].push_back(o_data[i]);
                end
                if (hold_v[i] && (!o_dv[i] || o_data[i] != hold_d[i]))
                    stab_bad[i] <= stab_bad[i] + 1;
                hold_v[i] <= o_dv[i] && !ds_ready[i];
                hold_d[i] <= o_data[i];
                if (pend[i]) begin
                    if (o_dv[i] && o_last[i]) pend[i] <= 1'b0;
                    else if (o_ready[i]) ready_viol[i] <= ready_viol[i] + 1;
                end
                if (in_dv[i] && o_ready[i]) begin
                    if (in_last[i] || cnt_m[i] + 1 == ((i == 0) ? MAXB0 : MAXB1)) begin
                        pend[i]  <= 1'b1;
                        cnt_m[i] <= 0;
                    end else begin
                        cnt_m[i] <= cnt_m[i] + 1;
                    end
                end
            end
        end
    end

    // Downstream ready: always 1, or a coin flip each cycle.
    initial begin
        ds_ready = 2'b11;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                ds_ready[i] = rand_ready ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int rd_ptr [2] = '{0, 0};

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive one frame starting at a negedge; ends at a negedge with i_DV low.
    task automatic send(input int inst, input logic [7:0] b[$], input bit term, input int gap_pct);
        int t;
        for (int i = 0; i < b.size(); i++) begin
            while ($urandom_range(99) < gap_pct) @(negedge clk);
            in_data[inst] = b[i];
            in_last[inst] = term && (i == b.size() - 1);
            in_dv[inst]   = 1'b1;
            t = 0;
            forever begin
                @(posedge clk);
                if (o_ready[inst]) break;
                t++;
                if (t > 500) begin
                    n_checks++; n_fail++;
                    $display("FAIL accept_timeout: inst %0d byte %0d never accepted", inst, i);
                    break;
                end
            end
            @(negedge clk);
            in_dv[inst]   = 1'b0;
            in_last[inst] = 1'b0;
        end
    endtask

    task automatic check_stream(input int inst, input string name, input logic [8:0] exp[$]);
        int t;
        t = 0;
        while (got_q[inst].size() < rd_ptr[inst] + exp.size() && t < 2000) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < exp.size(); k++) begin
            if (rd_ptr[inst] + k < got_q[inst].size()) begin
                cmp($sformatf("%s[%0d]", name, k), 32'(got_q[inst][rd_ptr[inst] + k]), 32'(exp[k]));
            end else begin
                n_checks++; n_fail++;
                $display("FAIL %s[%0d]: got no byte expected 0x%0h", name, k, exp[k]);
            end
        end
        rd_ptr[inst] = got_q[inst].size();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          len;
        logic [7:0]  pl [9];
        logic [15:0] crc;
    } vec_t;
    vec_t vt [2];

    initial begin
        logic [8:0]  exp[$];
        logic [7:0]  b[$];
        logic [7:0]  emitted[$];
        logic [15:0] r;
        int          errs1;
        int          n;

        for (int v = 0; v < 256; v++) begin
            r = 16'(v) << 8;
            for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
            crc_tab[v] = r;
        end

        vt[0].len = 9;
        for (int i = 0; i < 9; i++) vt[0].pl[i] = 8'h31 + 8'(i);
        vt[0].crc = 16'h29B1;
        vt[1].len = 1;
        for (int i = 0; i < 9; i++) vt[1].pl[i] = 8'h00;
        vt[1].pl[0] = 8'h41;
        vt[1].crc = 16'hB915;

        rand_ready = 1'b0;
        in_dv = '0; in_last = '0;
        in_data[0] = 8'h00; in_data[1] = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cmp($sformatf("rst_o_dv%0d", i), 32'(o_dv[i]), 0);
            cmp($sformatf("rst_o_data%0d", i), 32'(o_data[i]), 0);
            cmp($sformatf("rst_o_last%0d", i), 32'(o_last[i]), 0);
            cmp($sformatf("rst_o_err%0d", i), 32'(o_err[i]), 0);
`ifdef CRC_FRAME_TX_STATS_EN
            cmp($sformatf("rst_frame_cnt%0d", i), 32'(frame_cnt[i]), 0);
            cmp($sformatf("rst_trunc_cnt%0d", i), 32'(trunc_cnt[i]), 0);
`endif
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, downstream always ready, no input gaps.
        for (int v = 0; v < 2; v++) begin
            b.delete(); exp.delete();
            for (int i = 0; i < vt[v].len; i++) begin
                b.push_back(vt[v].pl[i]);
                exp.push_back({1'b0, vt[v].pl[i]});
            end
            exp.push_back({1'b0, vt[v].crc[15:8]});
            exp.push_back({1'b1, vt[v].crc[7:0]});
            n = rd_ptr[0];
            send(0, b, 1'b1, 0);
            check_stream(0, $sformatf("vec%0d", v), exp);
            emitted.delete();
            for (int k = n; k < got_q[0].size(); k++) emitted.push_back(got_q[0][k][7:0]);
            cmp($sformatf("vec%0d_residue", v), 32'(model_crc(emitted)), 0);
`ifdef CRC_FRAME_TX_STATS_EN
            cmp($sformatf("vec%0d_frame_cnt", v), 32'(frame_cnt[0]), 32'(v + 1));
`endif
        end
        cmp("vec_no_err", 32'(err_seen[0]), 0);

        // Same "123456789" with input gaps and downstream backpressure.
        rand_ready = 1'b1;
        b.delete(); exp.delete();
        for (int i = 0; i < 9; i++) begin
            b.push_back(8'h31 + 8'(i));
            exp.push_back({1'b0, 8'h31 + 8'(i)});
        end
        exp.push_back({1'b0, 8'h29});
        exp.push_back({1'b1, 8'hB1});
        send(0, b, 1'b1, 50);
        check_stream(0, "gapped", exp);
        cmp("gapped_stable", 32'(stab_bad[0]), 0);
        cmp("gapped_ready_low", 32'(ready_viol[0]), 0);

        // Truncation at 4 bytes: 6 bytes, last marker only on the sixth.
        rand_ready = 1'b0;
        b.delete(); exp.delete(); errs1 = 0;
        for (int i = 0; i < 6; i++) b.push_back(8'h10 + 8'(i));
        build_exp(MAXB1, b, 1'b1, exp, errs1);
        send(1, b, 1'b1, 0);
        check_stream(1, "trunc", exp);
        cmp("trunc_err_count", 32'(err_seen[1]), 1);
        cmp("trunc_err_byte", (err_data[1].size() > 0) ? 32'(err_data[1][0]) : 32'hFFFF_FFFF, 32'h13);
        cmp("trunc_ready_low", 32'(ready_viol[1]), 0);
`ifdef CRC_FRAME_TX_STATS_EN
        cmp("trunc_trunc_cnt", 32'(trunc_cnt[1]), 1);
        cmp("trunc_frame_cnt", 32'(frame_cnt[1]), 2);
`endif

        // Randomized frames on both instances against the reference model.
        rand_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            for (int inst = 0; inst < 2; inst++) begin
                b.delete(); exp.delete();
                n = $urandom_range(10, 1);
                for (int i = 0; i < n; i++) b.push_back(8'($urandom));
                build_exp((inst == 0) ? MAXB0 : MAXB1, b, 1'b1, exp, errs1);
                send(inst, b, 1'b1, 30);
                check_stream(inst, $sformatf("rand%0d_i%0d", f, inst), exp);
            end
        end
        cmp("rand_err0", 32'(err_seen[0]), 0);
        cmp("rand_err1", 32'(err_seen[1]), 32'(errs1));
        cmp("rand_stable0", 32'(stab_bad[0]), 0);
        cmp("rand_stable1", 32'(stab_bad[1]), 0);
        cmp("rand_ready_low0", 32'(ready_viol[0]), 0);
        cmp("rand_ready_low1", 32'(ready_viol[1]), 0);

        // Reset after byte 5 of a frame, then a clean frame.
        rand_ready = 1'b0;
        b.delete();
        for (int i = 0; i < 5; i++) b.push_back(8'h31 + 8'(i));
        send(0, b, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("midrst_o_dv", 32'(o_dv[0]), 0);
        cmp("midrst_o_data", 32'(o_data[0]), 0);
        cmp("midrst_o_last", 32'(o_last[0]), 0);
        cmp("midrst_o_err", 32'(o_err[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_ptr[0] = got_q[0].size();
        repeat (4) @(negedge clk);
        cmp("midrst_no_crc", 32'(got_q[0].size() - rd_ptr[0]), 0);
        b.delete(); exp.delete();
        for (int i = 0; i < 9; i++) begin
            b.push_back(8'h31 + 8'(i));
            exp.push_back({1'b0, 8'h31 + 8'(i)});
        end
        exp.push_back({1'b0, 8'h29});
        exp.push_back({1'b1, 8'hB1});
        send(0, b, 1'b1, 0);
        check_stream(0, "postrst", exp);
`ifdef CRC_FRAME_TX_STATS_EN
        cmp("postrst_frame_cnt", 32'(frame_cnt[0]), 1);
`endif

        repeat (5) @(negedge clk);
        cmp("no_extra0", 32'(got_q[0].size()), 32'(rd_ptr[0]));
        cmp("no_extra1", 32'(got_q[1].size()), 32'(rd_ptr[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
